cgra_cmd_loader: RTL and testbench

CGRA_CMD_LOADER -- requirements
Module: cgra_cmd_loader

---
 rtl/cgra_cmd_loader.sv | 161 ++++++++++++++++
 tb/tb_cgra_cmd_loader.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/cgra_cmd_loader.sv
// Byte-serial command loader for a 2x2 CGRA: decodes header/payload bytes into config/data write strobes and timed runs.
// Strobes appear one cycle after the final byte; in_ready drops during a run, and ena=0 freezes all state.
module cgra_cmd_loader (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic [7:0]  in_byte,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        cfg_we,
   output logic [1:0]  cfg_tile,
   output logic [3:0]  cfg_addr,
   output logic [15:0] cfg_wdata,
   output logic        data_we,
   output logic [7:0]  data_wdata,
   output logic        run,
   output logic        done,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, PAY0, PAY1, RUN} state_t;

   state_t      state_q, state_d;
   logic        wrdat_q, wrdat_d;
   logic [7:0]  pay_hi_q, pay_hi_d;
   logic [3:0]  run_cnt_q, run_cnt_d;
   logic [7:0]  idle_cnt_q, idle_cnt_d;
   logic        cfg_we_q, cfg_we_d;
   logic        data_we_q, data_we_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [1:0]  tile_q, tile_d;
   logic [3:0]  addr_q, addr_d;
   logic [15:0] cfg_wdata_q, cfg_wdata_d;
   logic [7:0]  data_wdata_q, data_wdata_d;
   logic        accept;

   // rst_n gates in_ready so it reads 0 while reset is held.
   assign in_ready = rst_n & ena & (state_q != RUN);
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_d      = state_q;
      wrdat_d      = wrdat_q;
      pay_hi_d     = pay_hi_q;
      run_cnt_d    = run_cnt_q;
      idle_cnt_d   = idle_cnt_q;
      cfg_we_d     = 1'b0;
      data_we_d    = 1'b0;
      done_d       = 1'b0;
      err_d        = err_q;
      tile_d       = tile_q;
      addr_d       = addr_q;
      cfg_wdata_d  = cfg_wdata_q;
      data_wdata_d = data_wdata_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               tile_d     = in_byte[5:4];
               addr_d     = in_byte[3:0];
               idle_cnt_d = 8'd0;
               case (in_byte[7:6])
                  2'b01: begin
                     state_d = PAY0;
                     wrdat_d = 1'b0;
                  end
                  2'b10: begin
                     state_d = PAY0;
                     wrdat_d = 1'b1;
                  end
                  2'b11: begin
                     state_d   = RUN;
                     run_cnt_d = in_byte[3:0];
                  end
                  default: ;
               endcase
            end
         end
         PAY0, PAY1: begin
            if (accept) begin
               idle_cnt_d = 8'd0;
               if (state_q == PAY1) begin
                  cfg_wdata_d = {pay_hi_q, in_byte};
                  cfg_we_d    = 1'b1;
                  state_d     = IDLE;
               end else if (wrdat_q) begin
                  data_wdata_d = in_byte;
                  data_we_d    = 1'b1;
                  state_d      = IDLE;
               end else begin
                  pay_hi_d = in_byte;
                  state_d  = PAY1;
               end
            end else if (ena) begin
               // Abandoned payload: drop the command silently and flag it.
               if (idle_cnt_q == 8'hFF) begin
                  state_d    = IDLE;
                  err_d      = 1'b1;
                  idle_cnt_d = 8'd0;
               end else begin
                  idle_cnt_d = idle_cnt_q + 8'd1;
               end
            end
         end
         RUN: begin
            if (ena) begin
               if (run_cnt_q == 4'd0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  run_cnt_d = run_cnt_q - 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         wrdat_q      <= 1'b0;
         pay_hi_q     <= 8'h00;
         run_cnt_q    <= 4'd0;
         idle_cnt_q   <= 8'd0;
         cfg_we_q     <= 1'b0;
         data_we_q    <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         tile_q       <= 2'd0;
         addr_q       <= 4'd0;
         cfg_wdata_q  <= 16'h0000;
         data_wdata_q <= 8'h00;
      end else begin
         state_q      <= state_d;
         wrdat_q      <= wrdat_d;
         pay_hi_q     <= pay_hi_d;
         run_cnt_q    <= run_cnt_d;
         idle_cnt_q   <= idle_cnt_d;
         cfg_we_q     <= cfg_we_d;
         data_we_q    <= data_we_d;
         done_q       <= done_d;
         err_q        <= err_d;
         tile_q       <= tile_d;
         addr_q       <= addr_d;
         cfg_wdata_q  <= cfg_wdata_d;
         data_wdata_q <= data_wdata_d;
      end
   end

   assign run        = (state_q == RUN);
   assign cfg_we     = cfg_we_q;
   assign data_we    = data_we_q;
   assign done       = done_q;
   assign err        = err_q;
   assign cfg_tile   = tile_q;
   assign cfg_addr   = addr_q;
   assign cfg_wdata  = cfg_wdata_q;
   assign data_wdata = data_wdata_q;

endmodule

// File: tb/tb_cgra_cmd_loader.sv
// Directed bench for cgra_cmd_loader: config/data writes, timed runs, ena freeze, payload timeout, mid-run reset.
module tb_cgra_cmd_loader;

   logic        clk = 1'b0;
   logic        rst_n, ena, in_valid;
   logic [7:0]  in_byte;
   logic        in_ready, cfg_we, data_we, run, done, err;
   logic [1:0]  cfg_tile;
   logic [3:0]  cfg_addr;
   logic [15:0] cfg_wdata;
   logic [7:0]  data_wdata;

   int vec  = 0;
   int miss = 0;

   cgra_cmd_loader dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .in_byte(in_byte), .in_valid(in_valid),
      .in_ready(in_ready), .cfg_we(cfg_we), .cfg_tile(cfg_tile), .cfg_addr(cfg_addr),
      .cfg_wdata(cfg_wdata), .data_we(data_we), .data_wdata(data_wdata),
      .run(run), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Presents one byte for one edge; returns 1 time unit after that edge.
   task automatic send(input logic [7:0] b);
      in_byte  = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; in_byte = 8'h00;
      #3;
      vec++; if ({in_ready, cfg_we, data_we, run, done, err} !== 6'b0) begin miss++; $display("FAIL reset_ctl got %b exp 000000", {in_ready, cfg_we, data_we, run, done, err}); end
      vec++; if ({cfg_tile, cfg_addr} !== 6'h00) begin miss++; $display("FAIL reset_tile_addr got %h exp 00", {cfg_tile, cfg_addr}); end
      vec++; if (cfg_wdata !== 16'h0000 || data_wdata !== 8'h00) begin miss++; $display("FAIL reset_data got %h/%h exp 0000/00", cfg_wdata, data_wdata); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      vec++; if (in_ready !== 1'b1) begin miss++; $display("FAIL ready_after_reset got %b exp 1", in_ready); end
   endtask

   task automatic test_wrcfg;
      send(8'h5A); send(8'hBE);
      vec++; if (cfg_we !== 1'b0) begin miss++; $display("FAIL wrcfg_early_we got %b exp 0", cfg_we); end
      send(8'hEF);
      vec++; if (cfg_we !== 1'b1 || data_we !== 1'b0) begin miss++; $display("FAIL wrcfg_we got %b/%b exp 1/0", cfg_we, data_we); end
      vec++; if ({cfg_tile, cfg_addr, cfg_wdata} !== {2'd1, 4'hA, 16'hBEEF}) begin miss++; $display("FAIL wrcfg_fields got %h %h %h exp 1 a beef", cfg_tile, cfg_addr, cfg_wdata); end
      @(posedge clk); #1;
      vec++; if (cfg_we !== 1'b0) begin miss++; $display("FAIL wrcfg_pulse_width got %b exp 0", cfg_we); end
   endtask

   task automatic test_wrdat;
      send(8'h83); send(8'h7F);
      vec++; if (data_we !== 1'b1 || cfg_we !== 1'b0) begin miss++; $display("FAIL wrdat_we got %b/%b exp 1/0", data_we, cfg_we); end
      vec++; if ({data_wdata, cfg_tile, cfg_addr} !== {8'h7F, 2'd0, 4'h3}) begin miss++; $display("FAIL wrdat_fields got %h %h %h exp 7f 0 3", data_wdata, cfg_tile, cfg_addr); end
      @(posedge clk); #1;
      vec++; if (data_we !== 1'b0 || cfg_wdata !== 16'hBEEF) begin miss++; $display("FAIL wrdat_after got we=%b cfg=%h exp 0 beef", data_we, cfg_wdata); end
   endtask

   task automatic test_run;
      int nrun = 0, ndone = 0;
      bit rdy_bad = 1'b0, done_rdy = 1'b0, dwe = 1'b0;
      send(8'hC4);
      in_byte = 8'h83; in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (run) begin nrun++; if (in_ready !== 1'b0) rdy_bad = 1'b1; end
         if (done) begin ndone++; done_rdy = in_ready; in_valid = 1'b0; end
         if (data_we) dwe = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      vec++; if (nrun != 5) begin miss++; $display("FAIL run_len got %0d exp 5", nrun); end
      vec++; if (ndone != 1) begin miss++; $display("FAIL run_done_count got %0d exp 1", ndone); end
      vec++; if (rdy_bad) begin miss++; $display("FAIL run_ready got 1 during run exp 0"); end
      vec++; if (done_rdy !== 1'b1) begin miss++; $display("FAIL done_ready got %b exp 1", done_rdy); end
      vec++; if (cfg_addr !== 4'h4 || dwe) begin miss++; $display("FAIL run_no_consume got addr=%h dwe=%b exp 4 0", cfg_addr, dwe); end
   endtask

   task automatic test_run_freeze;
      int nrun = 0, ndone = 0;
      send(8'hC1);
      ena = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vec++; if ({run, done, in_ready} !== 3'b100) begin miss++; $display("FAIL run_freeze got %b exp 100", {run, done, in_ready}); end
      ena = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (run) nrun++;
         if (done) ndone++;
         @(posedge clk); #1;
      end
      vec++; if (nrun != 2 || ndone != 1) begin miss++; $display("FAIL run_resume got run=%0d done=%0d exp 2 1", nrun, ndone); end
   endtask

   task automatic test_ena_hold;
      send(8'h5A);
      ena = 1'b0; in_byte = 8'h12; in_valid = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      vec++; if (in_ready !== 1'b0 || cfg_we !== 1'b0) begin miss++; $display("FAIL ena_hold got rdy=%b we=%b exp 0 0", in_ready, cfg_we); end
      ena = 1'b1;
      send(8'h12); send(8'h34);
      vec++; if (cfg_we !== 1'b1 || cfg_wdata !== 16'h1234) begin miss++; $display("FAIL ena_wrcfg got we=%b data=%h exp 1 1234", cfg_we, cfg_wdata); end
      vec++; if (err !== 1'b0) begin miss++; $display("FAIL ena_no_timeout got %b exp 0", err); end
   endtask

   task automatic test_timeout;
      bit saw = 1'b0;
      send(8'h41);
      repeat (240) begin @(posedge clk); #1; if (cfg_we) saw = 1'b1; end
      vec++; if (err !== 1'b0) begin miss++; $display("FAIL timeout_early got %b exp 0", err); end
      for (int i = 0; i < 60 && !err; i++) begin @(posedge clk); #1; if (cfg_we) saw = 1'b1; end
      vec++; if (err !== 1'b1) begin miss++; $display("FAIL timeout_err got %b exp 1", err); end
      vec++; if (saw || cfg_wdata !== 16'h1234) begin miss++; $display("FAIL timeout_no_write got we=%b data=%h exp 0 1234", saw, cfg_wdata); end
      send(8'h00);
      vec++; if ({cfg_tile, cfg_addr} !== 6'h00) begin miss++; $display("FAIL nop_header got %h exp 00", {cfg_tile, cfg_addr}); end
      @(posedge clk); #1;
      vec++; if (cfg_we !== 1'b0 || data_we !== 1'b0) begin miss++; $display("FAIL nop_strobe got %b/%b exp 0/0", cfg_we, data_we); end
      send(8'h83); send(8'h55);
      vec++; if (data_we !== 1'b1 || cfg_we !== 1'b0 || data_wdata !== 8'h55) begin miss++; $display("FAIL after_nop got %b/%b/%h exp 1/0/55", data_we, cfg_we, data_wdata); end
      vec++; if (err !== 1'b1) begin miss++; $display("FAIL err_sticky got %b exp 1", err); end
   endtask

   task automatic test_reset_mid_run;
      send(8'hCF);
      @(posedge clk); #1;
      @(posedge clk); #1;
      vec++; if (run !== 1'b1) begin miss++; $display("FAIL prereset_run got %b exp 1", run); end
      rst_n = 1'b0;
      #1;
      vec++; if ({in_ready, cfg_we, data_we, run, done, err} !== 6'b0) begin miss++; $display("FAIL midrun_reset_ctl got %b exp 000000", {in_ready, cfg_we, data_we, run, done, err}); end
      vec++; if ({cfg_tile, cfg_addr, cfg_wdata, data_wdata} !== 30'h0) begin miss++; $display("FAIL midrun_reset_data got %h exp 0", {cfg_tile, cfg_addr, cfg_wdata, data_wdata}); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      vec++; if (run !== 1'b0 || done !== 1'b0) begin miss++; $display("FAIL post_reset_idle got %b/%b exp 0/0", run, done); end
      send(8'h83); send(8'h11);
      vec++; if (data_we !== 1'b1 || data_wdata !== 8'h11 || cfg_addr !== 4'h3) begin miss++; $display("FAIL post_reset_header got %b/%h/%h exp 1/11/3", data_we, data_wdata, cfg_addr); end
   endtask

   initial begin
      test_reset;
      test_wrcfg;
      test_wrdat;
      test_run;
      test_run_freeze;
      test_ena_hold;
      test_timeout;
      test_reset_mid_run;
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
